// File: rtl/slv_guard_pkg.sv
// Shared types for the slave-guard transaction tracker: fault causes, FSM states
// and the per-slot record held by each slot timer.
package slv_guard_pkg;

    // Slot fields are sized for the widest supported configuration and zero-extended.
    localparam int MaxIdWidth  = 16;
    localparam int MaxCntWidth = 32;

    typedef enum logic [1:0] {
        CAUSE_TIMEOUT     = 2'd0,
        CAUSE_ID_CONFLICT = 2'd1,
        CAUSE_UNEXPECTED  = 2'd2,
        CAUSE_OVERFLOW    = 2'd3
    } fault_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FAULT = 2'd1,
        ST_CLEAR = 2'd2
    } fsm_state_e;

    typedef struct packed {
        logic                   busy;
        logic [MaxIdWidth-1:0]  id;
        logic [MaxCntWidth-1:0] timer;
        logic [MaxCntWidth-1:0] budget;
    } slot_t;

endpackage

// File: rtl/slv_guard_slot_timer.sv
// One outstanding-transaction slot: holds ID and budget, ages a saturating timer
// on each tick and flags expiry and ID matches.
module slv_guard_slot_timer
    import slv_guard_pkg::*;
#(
    parameter int IdWidth  = 4,
    parameter int CntWidth = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_all_i,
    input  logic                alloc_i,
    input  logic                free_i,
    input  logic                tick_i,
    input  logic [IdWidth-1:0]  alloc_id_i,
    input  logic [CntWidth-1:0] alloc_budget_i,
    input  logic [IdWidth-1:0]  req_id_i,
    input  logic [IdWidth-1:0]  rsp_id_i,
    output logic                busy_o,
    output logic                expired_o,
    output logic                req_match_o,
    output logic                rsp_match_o,
    output logic [IdWidth-1:0]  id_o
);

    localparam logic [MaxCntWidth-1:0] TimerMax = MaxCntWidth'((64'd1 << CntWidth) - 64'd1);

    slot_t slot_q;

    // Allocation wins over a same-cycle free so a retired slot can be reused at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q <= '0;
        end else if (clear_all_i) begin
            slot_q <= '0;
        end else if (alloc_i) begin
            slot_q.busy   <= 1'b1;
            slot_q.id     <= MaxIdWidth'(alloc_id_i);
            slot_q.timer  <= '0;
            slot_q.budget <= MaxCntWidth'(alloc_budget_i);
        end else if (free_i) begin
            slot_q.busy <= 1'b0;
        end else if (tick_i && slot_q.busy && (slot_q.timer != TimerMax)) begin
            slot_q.timer <= slot_q.timer + MaxCntWidth'(1);
        end
    end

    assign busy_o      = slot_q.busy;
    assign expired_o   = slot_q.busy && (slot_q.timer >= slot_q.budget);
    assign req_match_o = slot_q.busy && (slot_q.id == MaxIdWidth'(req_id_i));
    assign rsp_match_o = slot_q.busy && (slot_q.id == MaxIdWidth'(rsp_id_i));
    assign id_o        = slot_q.id[IdWidth-1:0];

endmodule

// File: rtl/slv_guard_txn_tracker.sv
// Slave guard: tracks outstanding request IDs against a per-transaction tick budget
// and raises a latched fault for timeouts, ID conflicts, stray responses and overflow.
module slv_guard_txn_tracker
    import slv_guard_pkg::*;
#(
    parameter int NumSlots       = 8,
    parameter int IdWidth        = 4,
    parameter int CntWidth       = 10,
    parameter int PrescalerDiv   = 8,
    parameter bit IsolateOnFault = 1'b1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            enable_i,
    input  logic                            req_valid_i,
    input  logic                            req_ready_i,
    input  logic [IdWidth-1:0]              req_id_i,
    input  logic [7:0]                      req_len_i,
    input  logic                            rsp_valid_i,
    input  logic                            rsp_ready_i,
    input  logic                            rsp_last_i,
    input  logic [IdWidth-1:0]              rsp_id_i,
    input  logic [CntWidth-1:0]             budget_base_i,
    input  logic [CntWidth-1:0]             budget_unit_i,
    input  logic                            clear_i,
    output logic                            irq_o,
    output logic                            isolate_o,
    output logic                            full_o,
    output logic [1:0]                      fault_cause_o,
    output logic [IdWidth-1:0]              fault_id_o,
    output logic [$clog2(NumSlots+1)-1:0]   outstanding_o,
    output fsm_state_e                      dbg_state_o
);

    localparam int OutW = $clog2(NumSlots + 1);
    localparam int PreW = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;
    localparam int BudW = CntWidth + 9;
    localparam logic [BudW-1:0] BudMax = BudW'((64'd1 << CntWidth) - 64'd1);

    fsm_state_e          state_q;
    logic                irq_q, isolate_q;
    fault_cause_e        cause_q, nxt_cause;
    logic [IdWidth-1:0]  fault_id_q, nxt_id, timeout_id;
    logic [PreW-1:0]     presc_q;

    logic [NumSlots-1:0] busy, expired, req_match, rsp_match;
    logic [NumSlots-1:0] avail, alloc_vec, free_vec, exp_oh;
    logic [IdWidth-1:0]  slot_id [NumSlots];

    logic idle, tick, req_ev, rsp_ev, rsp_hit, retire_same;
    logic f_conflict, f_overflow, f_unexp, f_timeout, fault_any, do_free, do_alloc;
    logic [BudW-1:0]     budget_wide;
    logic [CntWidth-1:0] budget_sat;

    // A beat transfers only on a cycle where both valid and ready are high; the guard
    // only observes the handshakes and never drives them.
    assign idle   = (state_q == ST_IDLE);
    assign tick   = enable_i && (presc_q == PreW'(PrescalerDiv - 1));
    assign req_ev = req_valid_i && req_ready_i && enable_i && idle;
    assign rsp_ev = rsp_valid_i && rsp_ready_i && rsp_last_i && enable_i && idle;

    assign full_o      = &busy;
    assign rsp_hit     = |rsp_match;
    assign retire_same = rsp_ev && rsp_hit && (rsp_id_i == req_id_i);
    assign f_conflict  = req_ev && (|req_match) && !retire_same;
    assign f_overflow  = req_ev && full_o;
    assign f_unexp     = rsp_ev && !rsp_hit;
    assign f_timeout   = idle && (|expired);
    assign fault_any   = f_conflict || f_overflow || f_unexp || f_timeout;
    assign do_free     = rsp_ev && rsp_hit && !fault_any;
    assign do_alloc    = req_ev && !fault_any;

    assign free_vec  = do_free ? rsp_match : '0;
    assign avail     = ~busy | free_vec;
    assign alloc_vec = do_alloc ? (avail & (~avail + NumSlots'(1))) : '0;
    assign exp_oh    = expired & (~expired + NumSlots'(1));

    assign budget_wide = BudW'(budget_base_i)
                       + BudW'(9'({1'b0, req_len_i}) + 9'd1) * BudW'(budget_unit_i);
    assign budget_sat  = (budget_wide > BudMax) ? {CntWidth{1'b1}} : budget_wide[CntWidth-1:0];

    for (genvar g = 0; g < NumSlots; g++) begin : g_slot
        slv_guard_slot_timer #(.IdWidth(IdWidth), .CntWidth(CntWidth)) u_timer (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .clear_all_i    (state_q == ST_CLEAR),
            .alloc_i        (alloc_vec[g]),
            .free_i         (free_vec[g]),
            .tick_i         (tick),
            .alloc_id_i     (req_id_i),
            .alloc_budget_i (budget_sat),
            .req_id_i       (req_id_i),
            .rsp_id_i       (rsp_id_i),
            .busy_o         (busy[g]),
            .expired_o      (expired[g]),
            .req_match_o    (req_match[g]),
            .rsp_match_o    (rsp_match[g]),
            .id_o           (slot_id[g])
        );
    end

    always_comb begin
        timeout_id    = '0;
        outstanding_o = '0;
        for (int i = 0; i < NumSlots; i++) begin
            timeout_id    = timeout_id | (exp_oh[i] ? slot_id[i] : '0);
            outstanding_o = outstanding_o + OutW'(busy[i]);
        end
    end

    always_comb begin
        nxt_cause = CAUSE_TIMEOUT;
        nxt_id    = timeout_id;
        if (f_conflict) begin
            nxt_cause = CAUSE_ID_CONFLICT;
            nxt_id    = req_id_i;
        end else if (f_overflow) begin
            nxt_cause = CAUSE_OVERFLOW;
            nxt_id    = req_id_i;
        end else if (f_unexp) begin
            nxt_cause = CAUSE_UNEXPECTED;
            nxt_id    = rsp_id_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            irq_q      <= 1'b0;
            isolate_q  <= 1'b0;
            cause_q    <= CAUSE_TIMEOUT;
            fault_id_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (fault_any) begin
                    state_q    <= ST_FAULT;
                    irq_q      <= 1'b1;
                    isolate_q  <= IsolateOnFault;
                    cause_q    <= nxt_cause;
                    fault_id_q <= nxt_id;
                end
                ST_FAULT: if (clear_i) begin
                    state_q <= ST_CLEAR;
                    irq_q   <= 1'b0;
                end
                ST_CLEAR: begin
                    state_q   <= ST_IDLE;
                    isolate_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    irq_q     <= 1'b0;
                    isolate_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
        end else if (!enable_i || (state_q == ST_CLEAR) || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PreW'(1);
        end
    end

    assign irq_o         = irq_q;
    assign isolate_o     = isolate_q;
    assign fault_cause_o = cause_q;
    assign fault_id_o    = fault_id_q;
    assign dbg_state_o   = state_q;

endmodule
